// File: rtl/leaf_seed_expand_pkg.sv
// Shared constants, state encoding and sizing helpers for the leaf seed
// expander that turns tree leaves into per-leaf XOF output streams.
package leaf_seed_expand_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_STREAM,
        S_FDONE,
        S_WACK,
        S_DONE
    } state_t;

    function automatic int lambda_of(input logic [15:0] ps);
        case (ps)
            "L3":    return 192;
            "L5":    return 256;
            default: return 128;
        endcase
    endfunction

    function automatic int words_of(input int bits);
        return bits / 32;
    endfunction

    // Leaves are the last level of a heap-ordered binary tree.
    function automatic int leaf_base_node(input int d);
        return (1 << d) - 1;
    endfunction

endpackage

// File: rtl/leaf_seed_expand.sv
// Walks every tree leaf in order, hashes salt||leaf_seed through the shared
// XOF and forwards the expanded words, tagged by leaf, downstream.
module leaf_seed_expand
    import leaf_seed_expand_pkg::*;
#(
    parameter logic [15:0] PARAMETER_SET = "L1",
    parameter int SEED_SIZE    = lambda_of(PARAMETER_SET),
    parameter int SALT_SIZE    = 2 * lambda_of(PARAMETER_SET),
    parameter int D_HYPERCUBE  = 8,
    parameter int OUT_SIZE     = 1024,
    parameter int TREEPRG_SIZE = SEED_SIZE * (2 ** (D_HYPERCUBE + 1)) + SEED_SIZE,
    localparam int SA_W = $clog2(SALT_SIZE / 32),
    localparam int TA_W = $clog2(TREEPRG_SIZE / 32),
    localparam int HA_W = $clog2((SEED_SIZE + SALT_SIZE) / 32)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    output logic                   o_done,
    output logic                   o_busy,
    output logic [SA_W-1:0]        o_salt_addr,
    output logic                   o_salt_rd,
    input  logic [31:0]            i_salt,
    output logic [TA_W-1:0]        o_seed_e_addr,
    output logic                   o_seed_e_rd,
    input  logic [31:0]            i_seed_e,
    output logic [31:0]            o_hash_data_in,
    input  logic [HA_W-1:0]        i_hash_addr,
    input  logic                   i_hash_rd_en,
    output logic [31:0]            o_hash_input_length,
    output logic [31:0]            o_hash_output_length,
    output logic                   o_hash_start,
    input  logic [31:0]            i_hash_data_out,
    input  logic                   i_hash_data_out_valid,
    output logic                   o_hash_data_out_ready,
    output logic                   o_hash_force_done,
    input  logic                   i_hash_force_done_ack,
    output logic [31:0]            o_share_data,
    output logic                   o_share_valid,
    input  logic                   i_share_ready,
    output logic [D_HYPERCUBE-1:0] o_share_leaf,
    output logic                   o_share_last
);

    localparam int SALT_W = words_of(SALT_SIZE);
    localparam int SEED_W = words_of(SEED_SIZE);
    localparam int NWORDS = words_of(OUT_SIZE);
    localparam int LC_W   = D_HYPERCUBE + 1;
    localparam int WC_W   = $clog2(NWORDS) + 1;
    localparam logic [LC_W-1:0] LAST_LEAF = LC_W'((1 << D_HYPERCUBE) - 1);
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(NWORDS - 1);

    state_t            state_q;
    logic [LC_W-1:0]   leaf_q;
    logic [WC_W-1:0]   word_q;
    logic              start_q;
    logic              fdone_q;
    logic              done_q;
    logic              busy_q;
    logic [HA_W-1:0]   haddr_q;
    logic              hrd_q;

    logic              in_stream;
    logic              salt_sel;
    logic              xfer;
    logic [TA_W-1:0]   leaf_word_base;

    assign o_hash_input_length  = 32'(SALT_SIZE + SEED_SIZE);
    assign o_hash_output_length = 32'(OUT_SIZE);

    assign salt_sel       = i_hash_addr < HA_W'(SALT_W);
    assign leaf_word_base = TA_W'((leaf_base_node(D_HYPERCUBE) + int'(leaf_q)) * SEED_W);

    assign o_salt_rd     = i_hash_rd_en;
    assign o_seed_e_rd   = i_hash_rd_en;
    assign o_salt_addr   = (i_hash_rd_en && salt_sel) ? SA_W'(i_hash_addr) : '0;
    assign o_seed_e_addr = (i_hash_rd_en && !salt_sel)
                         ? leaf_word_base + TA_W'(i_hash_addr) - TA_W'(SALT_W)
                         : '0;

    // Memories answer one cycle after the address, so steer on the delayed address.
    assign o_hash_data_in = !hrd_q ? '0
                          : (haddr_q < HA_W'(SALT_W)) ? i_salt : i_seed_e;

    assign in_stream             = state_q == S_STREAM;
    assign o_share_valid         = in_stream && i_hash_data_out_valid;
    assign o_hash_data_out_ready = in_stream && i_share_ready;
    assign o_share_data          = in_stream ? i_hash_data_out : '0;
    assign o_share_last          = o_share_valid && (word_q == LAST_WORD);
    assign o_share_leaf          = busy_q ? leaf_q[D_HYPERCUBE-1:0] : '0;
    assign xfer                  = o_share_valid && i_share_ready;

    assign o_hash_start      = start_q;
    assign o_hash_force_done = fdone_q;
    assign o_done            = done_q;
    assign o_busy            = busy_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            haddr_q <= '0;
            hrd_q   <= 1'b0;
        end else begin
            haddr_q <= i_hash_addr;
            hrd_q   <= i_hash_rd_en;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            leaf_q  <= '0;
            word_q  <= '0;
            start_q <= 1'b0;
            fdone_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            start_q <= 1'b0;
            fdone_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        leaf_q  <= '0;
                        word_q  <= '0;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    word_q  <= '0;
                    state_q <= S_STREAM;
                end
                S_STREAM: begin
                    if (xfer) begin
                        word_q <= word_q + WC_W'(1);
                        if (word_q == LAST_WORD) begin
                            fdone_q <= 1'b1;
                            state_q <= S_FDONE;
                        end
                    end
                end
                S_FDONE: state_q <= S_WACK;
                S_WACK: begin
                    if (i_hash_force_done_ack) begin
                        if (leaf_q == LAST_LEAF) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            leaf_q  <= leaf_q + LC_W'(1);
                            start_q <= 1'b1;
                            state_q <= S_START;
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_leaf_seed_expand.sv
// Randomised scoreboard bench for leaf_seed_expand: a behavioural hash core,
// salt/tree memories and a monitor that checks every forwarded word.
module tb_leaf_seed_expand;

    localparam int SEED_W     = 4;
    localparam int SALT_W     = 8;
    localparam int NW         = 32;
    localparam int NLEAF      = 256;
    localparam int TREE_WORDS = 2052;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic        o_done, o_busy;
    logic [2:0]  o_salt_addr;
    logic        o_salt_rd;
    logic [31:0] i_salt = '0;
    logic [11:0] o_seed_e_addr;
    logic        o_seed_e_rd;
    logic [31:0] i_seed_e = '0;
    logic [31:0] o_hash_data_in;
    logic [3:0]  i_hash_addr = '0;
    logic        i_hash_rd_en = 1'b0;
    logic [31:0] o_hash_input_length, o_hash_output_length;
    logic        o_hash_start;
    logic [31:0] i_hash_data_out = '0;
    logic        i_hash_data_out_valid = 1'b0;
    logic        o_hash_data_out_ready;
    logic        o_hash_force_done;
    logic        i_hash_force_done_ack = 1'b0;
    logic [31:0] o_share_data;
    logic        o_share_valid;
    logic        i_share_ready = 1'b0;
    logic [7:0]  o_share_leaf;
    logic        o_share_last;

    always #5 clk = ~clk;

    leaf_seed_expand dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start),
        .o_done(o_done), .o_busy(o_busy),
        .o_salt_addr(o_salt_addr), .o_salt_rd(o_salt_rd), .i_salt(i_salt),
        .o_seed_e_addr(o_seed_e_addr), .o_seed_e_rd(o_seed_e_rd),
        .i_seed_e(i_seed_e),
        .o_hash_data_in(o_hash_data_in), .i_hash_addr(i_hash_addr),
        .i_hash_rd_en(i_hash_rd_en),
        .o_hash_input_length(o_hash_input_length),
        .o_hash_output_length(o_hash_output_length),
        .o_hash_start(o_hash_start),
        .i_hash_data_out(i_hash_data_out),
        .i_hash_data_out_valid(i_hash_data_out_valid),
        .o_hash_data_out_ready(o_hash_data_out_ready),
        .o_hash_force_done(o_hash_force_done),
        .i_hash_force_done_ack(i_hash_force_done_ack),
        .o_share_data(o_share_data), .o_share_valid(o_share_valid),
        .i_share_ready(i_share_ready), .o_share_leaf(o_share_leaf),
        .o_share_last(o_share_last)
    );

    typedef struct {
        logic [31:0] d;
        int          leaf;
        bit          last;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] salt_mem[SALT_W];
    logic [31:0] tree_mem[TREE_WORDS];
    int          n_vec = 0;
    int          n_err = 0;
    int          n_starts = 0;
    bit          exp_rdy = 1'b0;
    bit          tog = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Registered-read memories.
    always @(posedge clk) begin
        if (o_salt_rd) i_salt <= salt_mem[o_salt_addr];
        if (o_seed_e_rd) i_seed_e <= tree_mem[o_seed_e_addr];
    end

    always @(negedge clk) begin
        if (!i_rst) begin
            chk("hash_ready", o_hash_data_out_ready, exp_rdy);
            if (o_share_valid && sb.size() > 0)
                chk("share_last", o_share_last, sb[0].last);
            if (o_share_valid && o_hash_data_out_ready) begin
                chk("queue_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("share_data", o_share_data, e.d);
                    chk("share_leaf", o_share_leaf, e.leaf);
                end
            end
        end
    end

    task automatic do_leaf(input int lf, input int rmode, input int ack_d,
                           input bit same_ack, input bit poke, input int abort_w,
                           output bit aborted);
        logic [31:0] w[NW];
        logic [31:0] ev;
        int k, guard, ad;
        bit v, r, sa;
        aborted = 1'b0;
        guard = 0;
        while (!o_hash_start && guard < 8) begin
            tick();
            guard++;
        end
        chk("hash_start_latency", guard, 0);
        if (!o_hash_start) begin
            aborted = 1'b1;
            return;
        end
        n_starts++;
        chk("busy_in_start", o_busy, 1);
        chk("start_leaf", o_share_leaf, lf);
        tick();
        for (int a = 0; a <= 12; a++) begin
            if (a > 0) begin
                ev = (a - 1 < SALT_W) ? salt_mem[a-1]
                   : tree_mem[(NLEAF - 1 + lf) * SEED_W + (a - 1 - SALT_W)];
                chk("hash_din", o_hash_data_in, ev);
            end
            if (a < 12) begin
                i_hash_addr = 4'(a);
                i_hash_rd_en = 1'b1;
                #1;
                chk("salt_rd", o_salt_rd, 1);
                chk("seed_rd", o_seed_e_rd, 1);
                chk("salt_addr", o_salt_addr, (a < SALT_W) ? a : 0);
                chk("seed_addr", o_seed_e_addr,
                    (a < SALT_W) ? 0 : (NLEAF - 1 + lf) * SEED_W + (a - SALT_W));
                tick();
            end
        end
        i_hash_rd_en = 1'b0;
        i_hash_addr = '0;
        for (int j = 0; j < NW; j++) begin
            w[j] = $urandom;
            sb.push_back('{d: w[j], leaf: lf, last: (j == NW - 1)});
        end
        k = 0;
        while (k < NW) begin
            if (abort_w >= 0 && k == abort_w) begin
                i_hash_data_out_valid = 1'b1;
                i_share_ready = 1'b1;
                exp_rdy = 1'b0;
                i_rst = 1'b1;
                tick();
                i_rst = 1'b0;
                chk("rst_valid", o_share_valid, 0);
                chk("rst_ready", o_hash_data_out_ready, 0);
                chk("rst_busy", o_busy, 0);
                chk("rst_leaf", o_share_leaf, 0);
                chk("rst_start", o_hash_start, 0);
                chk("rst_fdone", o_hash_force_done, 0);
                chk("rst_done", o_done, 0);
                chk("rst_data", o_share_data, 0);
                sb.delete();
                i_hash_data_out_valid = 1'b0;
                i_share_ready = 1'b0;
                aborted = 1'b1;
                return;
            end
            v = (rmode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            r = (rmode == 0) ? 1'b1 : (rmode == 1) ? tog : ($urandom_range(0, 3) != 0);
            tog = ~tog;
            i_hash_data_out = w[k];
            i_hash_data_out_valid = v;
            i_share_ready = r;
            exp_rdy = r;
            if (poke && $urandom_range(0, 7) == 0) i_start = 1'b1;
            tick();
            i_start = 1'b0;
            if (v && r) k++;
        end
        // Offer a 33rd word while force_done is up; it must not be taken.
        i_hash_data_out = $urandom;
        i_hash_data_out_valid = 1'b1;
        i_share_ready = 1'b1;
        exp_rdy = 1'b0;
        sa = same_ack;
        i_hash_force_done_ack = sa;
        #1;
        chk("force_done_latency", o_hash_force_done, 1);
        chk("no_valid_after_last", o_share_valid, 0);
        tick();
        i_hash_data_out_valid = 1'b0;
        i_share_ready = 1'b0;
        i_hash_force_done_ack = 1'b0;
        chk("force_done_pulse", o_hash_force_done, 0);
        ad = (ack_d < 0) ? $urandom_range(0, 3) : ack_d;
        for (int c = 0; c < ad; c++) begin
            chk("hold_in_wack", o_hash_start, 0);
            tick();
        end
        chk("hold_in_wack", o_hash_start, 0);
        i_hash_force_done_ack = 1'b1;
        tick();
        i_hash_force_done_ack = 1'b0;
    endtask

    task automatic run_pass(input int rmode, input int ack_d, input bit same_ack,
                            input bit poke, input int abort_leaf, output bit aborted);
        int s0;
        bit ab;
        s0 = n_starts;
        aborted = 1'b0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int lf = 0; lf < NLEAF; lf++) begin
            do_leaf(lf, rmode, ack_d, same_ack && (lf % 2 == 0), poke,
                    (lf == abort_leaf) ? 10 : -1, ab);
            if (ab) begin
                aborted = 1'b1;
                return;
            end
        end
        chk("done_pulse", o_done, 1);
        tick();
        chk("done_one_cycle", o_done, 0);
        chk("busy_after_done", o_busy, 0);
        chk("start_count", n_starts - s0, NLEAF);
        chk("queue_drained", sb.size(), 0);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ab;
        for (int i = 0; i < SALT_W; i++) salt_mem[i] = $urandom;
        for (int i = 0; i < TREE_WORDS; i++) tree_mem[i] = $urandom;
        i_rst = 1'b1;
        repeat (3) tick();
        chk("reset_busy", o_busy, 0);
        chk("reset_done", o_done, 0);
        chk("reset_start", o_hash_start, 0);
        chk("reset_fdone", o_hash_force_done, 0);
        chk("reset_valid", o_share_valid, 0);
        chk("reset_leaf", o_share_leaf, 0);
        chk("reset_din", o_hash_data_in, 0);
        chk("in_len", o_hash_input_length, 384);
        chk("out_len", o_hash_output_length, 1024);
        i_rst = 1'b0;
        tick();

        run_pass(0, 0, 1'b0, 1'b0, -1, ab);
        chk("pass1_complete", ab, 0);
        repeat (3) tick();

        run_pass(1, 5, 1'b1, 1'b0, 17, ab);
        chk("pass2_aborted", ab, 1);
        for (int c = 0; c < 6; c++) begin
            chk("no_done_after_rst", o_done, 0);
            chk("idle_after_rst", o_busy, 0);
            tick();
        end

        run_pass(2, -1, 1'b1, 1'b1, -1, ab);
        chk("pass3_complete", ab, 0);
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/leaf_seed_expand.md
# leaf_seed_expand

- Downstream consumer of the seed-tree PRG stage; runs after the tree has finished.
- Reads each of the 2^D_HYPERCUBE leaf seeds from the tree memory's read port and drives the shared hash/XOF core with salt||leaf_seed.
- Streams OUT_SIZE bits of expanded randomness per leaf, tagged with the leaf index, to the share-generation stage.
- Processes leaves strictly in order 0 .. 2^D_HYPERCUBE-1.

## Interface
- PARAMETER_SET, "L1": selects LAMBDA (L1 128, L3 192, L5 256, default 128).
- SEED_SIZE, LAMBDA: leaf seed bits.
- SALT_SIZE, 2*LAMBDA: salt bits.
- D_HYPERCUBE, 8: leaf count is 2^D_HYPERCUBE.
- OUT_SIZE, 1024: XOF output bits per leaf; multiple of 32.
- TREEPRG_SIZE, SEED_SIZE*(2^(D_HYPERCUBE+1))+SEED_SIZE: tree memory bits, used for address width.
- i_clk  in  1  sole clock.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  start pulse; honoured only in IDLE.
- o_done  out  1  one-cycle pulse after the last leaf.
- o_busy  out  1  high from the cycle after i_start until o_done.
- o_salt_addr  out  CLOG2(SALT_SIZE/32)  salt word address.
- o_salt_rd  out  1  salt read strobe.
- i_salt  in  32  salt word, one cycle after the address.
- o_seed_e_addr  out  CLOG2(TREEPRG_SIZE/32)  tree word address.
- o_seed_e_rd  out  1  tree read strobe.
- i_seed_e  in  32  tree word, one cycle after the address.
- o_hash_data_in  out  32  hash input word.
- i_hash_addr  in  CLOG2((SEED_SIZE+SALT_SIZE)/32)  hash input word address.
- i_hash_rd_en  in  1  hash input read.
- o_hash_input_length  out  32  constant SALT_SIZE+SEED_SIZE.
- o_hash_output_length  out  32  constant OUT_SIZE.
- o_hash_start  out  1  one-cycle start pulse per leaf.
- i_hash_data_out  in  32  hash output word.
- i_hash_data_out_valid  in  1  hash output valid.
- o_hash_data_out_ready  out  1  hash output ready.
- o_hash_force_done  out  1  one-cycle pulse that terminates the XOF.
- i_hash_force_done_ack  in  1  XOF termination acknowledge.
- o_share_data  out  32  expanded word.
- o_share_valid  out  1  o_share_data valid.
- i_share_ready  in  1  consumer ready.
- o_share_leaf  out  D_HYPERCUBE  index of the current leaf.
- o_share_last  out  1  marks the final word of a leaf.

## Operation
- **Leaf address:** leaf j is tree node 2^D_HYPERCUBE-1+j. Its word address is (2^D_HYPERCUBE-1+j)*SEED_SIZE/32 + k, for k = 0..SEED_SIZE/32-1.
- **Hash read mux:** when hash address a < SALT_SIZE/32, drive o_salt_addr=a. Otherwise drive o_seed_e_addr = leaf_base + a - SALT_SIZE/32.
  - Both strobes equal i_hash_rd_en; addresses are 0 when not reading.
  - o_hash_data_in selects i_salt or i_seed_e using a one-cycle-registered copy of i_hash_addr.
- **States:**
  - IDLE: on i_start, clear the leaf and word counters and go to START.
  - START: assert o_hash_start for this one cycle, then go to STREAM.
  - STREAM: connect o_share_data=i_hash_data_out, o_share_valid=i_hash_data_out_valid and o_hash_data_out_ready=i_share_ready. Increment the word counter on each valid&&ready. After OUT_SIZE/32 transfers, go to FDONE.
  - FDONE: pulse o_hash_force_done for one cycle, then go to WACK.
  - WACK: wait for i_hash_force_done_ack. If leaf == 2^D_HYPERCUBE-1, go to DONE. Otherwise increment leaf and go to START.
  - DONE: pulse o_done, then go to IDLE.
- **Counters:** leaf counter is D_HYPERCUBE+1 bits; word counter is CLOG2(OUT_SIZE/32)+1 bits. Neither wraps.
- **o_share_last:** valid && word counter == OUT_SIZE/32-1.
- **o_share_leaf:** holds the current leaf for the whole leaf, including START, FDONE and WACK.

## Timing
- **Reset values:** every output register is 0 and state is IDLE. Combinational outputs evaluate to 0 in IDLE.
- **Reset mid-operation:** state returns to IDLE on the next edge with all outputs 0 and no o_done. The hash core is not force-terminated; its reset is the system's concern.
- **i_start while busy:** ignored.
- **Latency:** i_start to o_hash_start is 1 cycle. Last transfer to o_hash_force_done is 1 cycle.
- **Back-pressure:** words are lossless under i_share_ready back-pressure; the hash core stalls because ready is low.
- **Word boundary:** an (OUT_SIZE/32+1)-th valid word is never accepted; ready is 0 outside STREAM.
- **Ack timing:** an i_hash_force_done_ack in the same cycle as o_hash_force_done is not sampled. The ack is honoured from the WACK cycle onward.

## Structure
- Shared package holds the PARAMETER_SET→LAMBDA mapping, the SEED/SALT word counts, the leaf-base formula constant 2^D_HYPERCUBE-1, and the state encodings.
- No sub-module; a single FSM and datapath. The tree and salt memories stay external.

## Test plan
- L1, D=8, OUT_SIZE=1024, i_share_ready=1: leaf 0 reads tree words 1020..1023, leaf 255 reads words 2040..2043. Expect 256 leaves × 32 words = 8192 transfers, 256 o_hash_start pulses and one o_done.
- Hash reads addresses 0..11: salt addresses 0..7, then tree addresses base+0..3. o_hash_data_in matches the memory model one cycle later.
- i_share_ready toggling 1/0 each cycle: no word is dropped or duplicated, and o_share_last is asserted exactly on word 31 of each leaf.
- i_hash_force_done_ack delayed 5 cycles: the FSM holds in WACK with no o_hash_start. Ack in the same cycle as force_done is ignored.
- i_rst asserted during leaf 17 STREAM: all outputs are 0 next cycle and there is no o_done. A new i_start restarts from leaf 0.
- i_start asserted during STREAM: no effect on the leaf or word counters.
